// File: rtl/axi_lite_arbiter_2to1.sv
// Two-requester AXI4-Lite arbiter: independent round-robin read and write paths,
// one outstanding transaction per path, zero-cycle pass-through once granted.
//
// state  | meaning
// W_IDLE | no write in flight; picks the next write winner
// W_XFER | aw/w of the granted requester routed downstream until both handshake
// W_RESP | b routed back to the granted requester
// R_IDLE | no read in flight; picks the next read winner
// R_ADDR | ar of the granted requester routed downstream
// R_DATA | r routed back to the granted requester
module axi_lite_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_s0_axi_aw_valid,
  output logic                    io_s0_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s0_axi_aw_bits_addr,
  input  logic                    io_s0_axi_w_valid,
  output logic                    io_s0_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_s0_axi_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] io_s0_axi_w_bits_strb,
  output logic                    io_s0_axi_b_valid,
  input  logic                    io_s0_axi_b_ready,
  output logic [1:0]              io_s0_axi_b_bits_resp,
  input  logic                    io_s0_axi_ar_valid,
  output logic                    io_s0_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s0_axi_ar_bits_addr,
  output logic                    io_s0_axi_r_valid,
  input  logic                    io_s0_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   io_s0_axi_r_bits_data,
  output logic [1:0]              io_s0_axi_r_bits_resp,
  input  logic                    io_s1_axi_aw_valid,
  output logic                    io_s1_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s1_axi_aw_bits_addr,
  input  logic                    io_s1_axi_w_valid,
  output logic                    io_s1_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_s1_axi_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] io_s1_axi_w_bits_strb,
  output logic                    io_s1_axi_b_valid,
  input  logic                    io_s1_axi_b_ready,
  output logic [1:0]              io_s1_axi_b_bits_resp,
  input  logic                    io_s1_axi_ar_valid,
  output logic                    io_s1_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s1_axi_ar_bits_addr,
  output logic                    io_s1_axi_r_valid,
  input  logic                    io_s1_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   io_s1_axi_r_bits_data,
  output logic [1:0]              io_s1_axi_r_bits_resp,
  output logic                    io_m_axi_aw_valid,
  input  logic                    io_m_axi_aw_ready,
  output logic [ADDR_WIDTH-1:0]   io_m_axi_aw_bits_addr,
  output logic                    io_m_axi_w_valid,
  input  logic                    io_m_axi_w_ready,
  output logic [DATA_WIDTH-1:0]   io_m_axi_w_bits_data,
  output logic [DATA_WIDTH/8-1:0] io_m_axi_w_bits_strb,
  input  logic                    io_m_axi_b_valid,
  output logic                    io_m_axi_b_ready,
  input  logic [1:0]              io_m_axi_b_bits_resp,
  output logic                    io_m_axi_ar_valid,
  input  logic                    io_m_axi_ar_ready,
  output logic [ADDR_WIDTH-1:0]   io_m_axi_ar_bits_addr,
  input  logic                    io_m_axi_r_valid,
  output logic                    io_m_axi_r_ready,
  input  logic [DATA_WIDTH-1:0]   io_m_axi_r_bits_data,
  input  logic [1:0]              io_m_axi_r_bits_resp
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic grant_w, grant_w_nxt, last_w, last_w_nxt;
  logic aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic grant_r, grant_r_nxt, last_r, last_r_nxt;

  logic w_req0, w_req1, w_win, r_win;
  logic g_aw_valid, g_w_valid, g_b_ready, g_ar_valid, g_r_ready;
  logic aw_hs, w_hs;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

  // the pointer remembers the last winner; on a tie the other requester wins
  assign w_req0 = io_s0_axi_aw_valid | io_s0_axi_w_valid;
  assign w_req1 = io_s1_axi_aw_valid | io_s1_axi_w_valid;
  assign w_win  = (w_req0 & w_req1) ? ~last_w : w_req1;
  assign r_win  = (io_s0_axi_ar_valid & io_s1_axi_ar_valid) ? ~last_r : io_s1_axi_ar_valid;

  assign g_aw_valid = grant_w ? io_s1_axi_aw_valid : io_s0_axi_aw_valid;
  assign g_w_valid  = grant_w ? io_s1_axi_w_valid  : io_s0_axi_w_valid;
  assign g_b_ready  = grant_w ? io_s1_axi_b_ready  : io_s0_axi_b_ready;
  assign g_ar_valid = grant_r ? io_s1_axi_ar_valid : io_s0_axi_ar_valid;
  assign g_r_ready  = grant_r ? io_s1_axi_r_ready  : io_s0_axi_r_ready;

  assign io_m_axi_aw_bits_addr = grant_w ? io_s1_axi_aw_bits_addr : io_s0_axi_aw_bits_addr;
  assign io_m_axi_w_bits_data  = grant_w ? io_s1_axi_w_bits_data  : io_s0_axi_w_bits_data;
  assign io_m_axi_w_bits_strb  = grant_w ? io_s1_axi_w_bits_strb  : io_s0_axi_w_bits_strb;
  assign io_m_axi_ar_bits_addr = grant_r ? io_s1_axi_ar_bits_addr : io_s0_axi_ar_bits_addr;

  // a channel that already handshook is masked so it never issues twice
  assign aw_hs = (w_state == W_XFER) & g_aw_valid & ~aw_done & io_m_axi_aw_ready;
  assign w_hs  = (w_state == W_XFER) & g_w_valid  & ~w_done  & io_m_axi_w_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state <= W_IDLE;
      grant_w <= 1'b0;
      last_w  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      r_state <= R_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      w_state <= w_state_nxt;
      grant_w <= grant_w_nxt;
      last_w  <= last_w_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      r_state <= r_state_nxt;
      grant_r <= grant_r_nxt;
      last_r  <= last_r_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = w_state;
    grant_w_nxt       = grant_w;
    last_w_nxt        = last_w;
    aw_done_nxt       = aw_done;
    w_done_nxt        = w_done;
    io_m_axi_aw_valid = 1'b0;
    io_m_axi_w_valid  = 1'b0;
    io_m_axi_b_ready  = 1'b0;
    aw_rdy            = 1'b0;
    w_rdy             = 1'b0;
    b_vld             = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (w_req0 | w_req1) begin
          grant_w_nxt = w_win;
          last_w_nxt  = w_win;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = W_XFER;
        end
      end
      W_XFER: begin
        io_m_axi_aw_valid = g_aw_valid & ~aw_done;
        io_m_axi_w_valid  = g_w_valid & ~w_done;
        aw_rdy            = io_m_axi_aw_ready & ~aw_done;
        w_rdy             = io_m_axi_w_ready & ~w_done;
        aw_done_nxt       = aw_done | aw_hs;
        w_done_nxt        = w_done | w_hs;
        if ((aw_done | aw_hs) & (w_done | w_hs)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        io_m_axi_b_ready = g_b_ready;
        b_vld            = io_m_axi_b_valid;
        if (io_m_axi_b_valid & g_b_ready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt       = r_state;
    grant_r_nxt       = grant_r;
    last_r_nxt        = last_r;
    io_m_axi_ar_valid = 1'b0;
    io_m_axi_r_ready  = 1'b0;
    ar_rdy            = 1'b0;
    r_vld             = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (io_s0_axi_ar_valid | io_s1_axi_ar_valid) begin
          grant_r_nxt = r_win;
          last_r_nxt  = r_win;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        io_m_axi_ar_valid = g_ar_valid;
        ar_rdy            = io_m_axi_ar_ready;
        if (g_ar_valid & io_m_axi_ar_ready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        io_m_axi_r_ready = g_r_ready;
        r_vld            = io_m_axi_r_valid;
        if (io_m_axi_r_valid & g_r_ready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign io_s0_axi_aw_ready    = aw_rdy & ~grant_w;
  assign io_s1_axi_aw_ready    = aw_rdy & grant_w;
  assign io_s0_axi_w_ready     = w_rdy & ~grant_w;
  assign io_s1_axi_w_ready     = w_rdy & grant_w;
  assign io_s0_axi_b_valid     = b_vld & ~grant_w;
  assign io_s1_axi_b_valid     = b_vld & grant_w;
  assign io_s0_axi_b_bits_resp = (b_vld & ~grant_w) ? io_m_axi_b_bits_resp : 2'b00;
  assign io_s1_axi_b_bits_resp = (b_vld & grant_w) ? io_m_axi_b_bits_resp : 2'b00;
  assign io_s0_axi_ar_ready    = ar_rdy & ~grant_r;
  assign io_s1_axi_ar_ready    = ar_rdy & grant_r;
  assign io_s0_axi_r_valid     = r_vld & ~grant_r;
  assign io_s1_axi_r_valid     = r_vld & grant_r;
  assign io_s0_axi_r_bits_data = (r_vld & ~grant_r) ? io_m_axi_r_bits_data : '0;
  assign io_s1_axi_r_bits_data = (r_vld & grant_r) ? io_m_axi_r_bits_data : '0;
  assign io_s0_axi_r_bits_resp = (r_vld & ~grant_r) ? io_m_axi_r_bits_resp : 2'b00;
  assign io_s1_axi_r_bits_resp = (r_vld & grant_r) ? io_m_axi_r_bits_resp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: two scripted requesters, a small memory
// slave downstream, and per-requester response scoreboards.
module tb_axi_lite_arbiter_2to1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        s_aw_valid [2], s_aw_ready [2], s_w_valid [2], s_w_ready [2];
  logic        s_b_valid [2], s_b_ready [2], s_ar_valid [2], s_ar_ready [2];
  logic        s_r_valid [2], s_r_ready [2];
  logic [31:0] s_aw_addr [2], s_w_data [2], s_ar_addr [2], s_r_data [2];
  logic [3:0]  s_w_strb [2];
  logic [1:0]  s_b_resp [2], s_r_resp [2];

  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_b_resp, m_r_resp;

  axi_lite_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .io_s0_axi_aw_valid(s_aw_valid[0]), .io_s0_axi_aw_ready(s_aw_ready[0]), .io_s0_axi_aw_bits_addr(s_aw_addr[0]),
    .io_s0_axi_w_valid(s_w_valid[0]), .io_s0_axi_w_ready(s_w_ready[0]),
    .io_s0_axi_w_bits_data(s_w_data[0]), .io_s0_axi_w_bits_strb(s_w_strb[0]),
    .io_s0_axi_b_valid(s_b_valid[0]), .io_s0_axi_b_ready(s_b_ready[0]), .io_s0_axi_b_bits_resp(s_b_resp[0]),
    .io_s0_axi_ar_valid(s_ar_valid[0]), .io_s0_axi_ar_ready(s_ar_ready[0]), .io_s0_axi_ar_bits_addr(s_ar_addr[0]),
    .io_s0_axi_r_valid(s_r_valid[0]), .io_s0_axi_r_ready(s_r_ready[0]),
    .io_s0_axi_r_bits_data(s_r_data[0]), .io_s0_axi_r_bits_resp(s_r_resp[0]),
    .io_s1_axi_aw_valid(s_aw_valid[1]), .io_s1_axi_aw_ready(s_aw_ready[1]), .io_s1_axi_aw_bits_addr(s_aw_addr[1]),
    .io_s1_axi_w_valid(s_w_valid[1]), .io_s1_axi_w_ready(s_w_ready[1]),
    .io_s1_axi_w_bits_data(s_w_data[1]), .io_s1_axi_w_bits_strb(s_w_strb[1]),
    .io_s1_axi_b_valid(s_b_valid[1]), .io_s1_axi_b_ready(s_b_ready[1]), .io_s1_axi_b_bits_resp(s_b_resp[1]),
    .io_s1_axi_ar_valid(s_ar_valid[1]), .io_s1_axi_ar_ready(s_ar_ready[1]), .io_s1_axi_ar_bits_addr(s_ar_addr[1]),
    .io_s1_axi_r_valid(s_r_valid[1]), .io_s1_axi_r_ready(s_r_ready[1]),
    .io_s1_axi_r_bits_data(s_r_data[1]), .io_s1_axi_r_bits_resp(s_r_resp[1]),
    .io_m_axi_aw_valid(m_aw_valid), .io_m_axi_aw_ready(m_aw_ready), .io_m_axi_aw_bits_addr(m_aw_addr),
    .io_m_axi_w_valid(m_w_valid), .io_m_axi_w_ready(m_w_ready),
    .io_m_axi_w_bits_data(m_w_data), .io_m_axi_w_bits_strb(m_w_strb),
    .io_m_axi_b_valid(m_b_valid), .io_m_axi_b_ready(m_b_ready), .io_m_axi_b_bits_resp(m_b_resp),
    .io_m_axi_ar_valid(m_ar_valid), .io_m_axi_ar_ready(m_ar_ready), .io_m_axi_ar_bits_addr(m_ar_addr),
    .io_m_axi_r_valid(m_r_valid), .io_m_axi_r_ready(m_r_ready),
    .io_m_axi_r_bits_data(m_r_data), .io_m_axi_r_bits_resp(m_r_resp)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- downstream memory slave ----------------
  logic [31:0] mem [16];
  int          b_hold, r_hold, b_cnt, r_cnt;
  logic [1:0]  slv_bresp, slv_rresp;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_b_valid <= 1'b0; m_r_valid <= 1'b0; m_b_resp <= 2'b00; m_r_resp <= 2'b00; m_r_data <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0; b_cnt <= 0; r_cnt <= 0;
      aw_a <= 32'h0; w_d <= 32'h0; w_s <= 4'h0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hCAFE_F00D;
      mem[1] <= 32'h1234_5678;
    end else begin
      if (m_aw_valid && m_aw_ready) begin aw_got <= 1'b1; aw_a <= m_aw_addr; end
      if (m_w_valid && m_w_ready) begin w_got <= 1'b1; w_d <= m_w_data; w_s <= m_w_strb; end
      if (aw_got && w_got) begin
        mem[aw_a[5:2]] <= merge(mem[aw_a[5:2]], w_d, w_s);
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= b_hold;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin m_b_valid <= 1'b1; m_b_resp <= slv_bresp; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (m_b_valid && m_b_ready) m_b_valid <= 1'b0;
      if (m_ar_valid && m_ar_ready) begin
        r_pend <= 1'b1; r_cnt <= r_hold; m_r_data <= mem[m_ar_addr[5:2]]; m_r_resp <= slv_rresp;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin m_r_valid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (m_r_valid && m_r_ready) m_r_valid <= 1'b0;
    end
  end

  // ---------------- scoreboards ----------------
  logic [33:0] rq0 [$], rq1 [$];
  logic [1:0]  bq0 [$], bq1 [$];
  int r_hs_cyc [2], b_hs_cyc [2];
  int m_aw_vcnt = 0;
  logic [33:0] mon_re;
  logic [1:0]  mon_be;

  function automatic int q_size(input int p, input logic is_b);
    if (is_b) return (p == 0) ? bq0.size() : bq1.size();
    return (p == 0) ? rq0.size() : rq1.size();
  endfunction

  always @(negedge clock) begin
    if (m_aw_valid) m_aw_vcnt++;
    for (int p = 0; p < 2; p++) begin
      if (s_r_valid[p] && s_r_ready[p]) begin
        r_hs_cyc[p] = cyc;
        if (q_size(p, 1'b0) == 0) chk($sformatf("r_unexpected_s%0d", p), 32'(s_r_valid[p]), 32'h0);
        else begin
          mon_re = (p == 0) ? rq0.pop_front() : rq1.pop_front();
          chk($sformatf("r_data_s%0d", p), s_r_data[p], mon_re[31:0]);
          chk($sformatf("r_resp_s%0d", p), 32'(s_r_resp[p]), 32'(mon_re[33:32]));
        end
      end else if (q_size(p, 1'b0) == 0) chk($sformatf("r_idle_s%0d", p), 32'(s_r_valid[p]), 32'h0);
      if (s_b_valid[p] && s_b_ready[p]) begin
        b_hs_cyc[p] = cyc;
        if (q_size(p, 1'b1) == 0) chk($sformatf("b_unexpected_s%0d", p), 32'(s_b_valid[p]), 32'h0);
        else begin
          mon_be = (p == 0) ? bq0.pop_front() : bq1.pop_front();
          chk($sformatf("b_resp_s%0d", p), 32'(s_b_resp[p]), 32'(mon_be));
        end
      end else if (q_size(p, 1'b1) == 0) chk($sformatf("b_idle_s%0d", p), 32'(s_b_valid[p]), 32'h0);
    end
  end

  // ---------------- requester tasks ----------------
  function automatic logic rdy_of(input int p, input int ch);
    case (ch)
      0: return s_aw_ready[p];
      1: return s_w_ready[p];
      default: return s_ar_ready[p];
    endcase
  endfunction

  // lat = cycles the valid was shown before ready appeared; returns at posedge+1 after the handshake
  task automatic wait_hs(input int p, input int ch, output int seen, output int lat);
    logic got;
    got = 1'b0; lat = 0; seen = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (rdy_of(p, ch)) begin got = 1'b1; seen = cyc; break; end
      lat++;
    end
    chk($sformatf("hs_timeout_s%0d_ch%0d", p, ch), 32'(got), 32'h1);
    @(posedge clock); #1;
  endtask

  task automatic wait_q(input int p, input logic is_b);
    for (int i = 0; i < 300; i++) begin
      if (q_size(p, is_b) == 0) break;
      @(posedge clock); #1;
    end
    chk($sformatf("resp_timeout_s%0d_b%0d", p, is_b), q_size(p, is_b), 32'h0);
  endtask

  task automatic rd(input int p, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                    output int rc, output int rl);
    if (p == 0) rq0.push_back({er, ed}); else rq1.push_back({er, ed});
    s_ar_valid[p] = 1'b1; s_ar_addr[p] = a;
    wait_hs(p, 2, rc, rl);
    s_ar_valid[p] = 1'b0;
    wait_q(p, 1'b0);
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_dly, input logic [1:0] er, output int ac, output int al, output int wl);
    int wc;
    if (p == 0) bq0.push_back(er); else bq1.push_back(er);
    fork
      begin
        s_aw_valid[p] = 1'b1; s_aw_addr[p] = a;
        wait_hs(p, 0, ac, al);
        s_aw_valid[p] = 1'b0;
      end
      begin
        if (w_dly > 0) begin repeat (w_dly) @(posedge clock); #1; end
        s_w_valid[p] = 1'b1; s_w_data[p] = d; s_w_strb[p] = s;
        wait_hs(p, 1, wc, wl);
        s_w_valid[p] = 1'b0;
      end
    join
    wait_q(p, 1'b1);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {17'h0, s_aw_ready[0], s_aw_ready[1], s_w_ready[0], s_w_ready[1], s_b_valid[0], s_b_valid[1],
              s_ar_ready[0], s_ar_ready[1], s_r_valid[0], s_r_valid[1],
              m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  int c0, c1, l0, l1, w0, w1;

  initial begin
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      s_aw_valid[p] = 1'b0; s_w_valid[p] = 1'b0; s_ar_valid[p] = 1'b0;
      s_aw_addr[p] = 32'h0; s_w_data[p] = 32'h0; s_w_strb[p] = 4'h0; s_ar_addr[p] = 32'h0;
      s_b_ready[p] = 1'b1; s_r_ready[p] = 1'b1;
      r_hs_cyc[p] = 0; b_hs_cyc[p] = 0;
    end
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    b_hold = 0; r_hold = 0; slv_bresp = 2'b00; slv_rresp = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_quiet("reset_outputs");
    @(posedge clock); #1;
    reset = 1'b1;

    // first tie after reset goes to s0; s1 granted after one idle cycle following s0's r handshake
    fork
      rd(0, 32'h0800_0004, 32'h1234_5678, 2'b00, c0, l0);
      rd(1, 32'h2000_0000, 32'hCAFE_F00D, 2'b00, c1, l1);
    join
    chk("pair1_s0_latency", l0, 1);
    chk("pair1_s0_first", 32'(c0 < c1), 32'h1);
    chk("pair1_s1_after_r_hs", c1 - r_hs_cyc[0], 2);

    // lone s0 read; leaves the read pointer at s0
    rd(0, 32'h0800_0004, 32'h1234_5678, 2'b00, c0, l0);
    chk("single_s0_ar_latency", l0, 1);

    // pointer now favours s1 on the next tie
    fork
      rd(0, 32'h0800_0004, 32'h1234_5678, 2'b00, c0, l0);
      rd(1, 32'h2000_0000, 32'hCAFE_F00D, 2'b00, c1, l1);
    join
    chk("pair2_s1_first", 32'(c1 < c0), 32'h1);
    chk("pair2_s1_latency", l1, 1);

    // s1 write with w three cycles after aw, then read back through s0
    m_aw_vcnt = 0;
    wr(1, 32'h0800_0004, 32'hDEAD_BEEF, 4'hF, 3, 2'b00, c1, l1, w1);
    chk("wr_s1_aw_latency", l1, 1);
    chk("wr_s1_w_latency", w1, 0);
    chk("wr_m_aw_valid_cycles", m_aw_vcnt, 1);
    rd(0, 32'h0800_0004, 32'hDEAD_BEEF, 2'b00, c0, l0);

    // independent paths: s0 write and s1 read granted in the same cycle
    fork
      wr(0, 32'h0800_0008, 32'hA5A5_1234, 4'hC, 0, 2'b00, c0, l0, w0);
      rd(1, 32'h2000_0000, 32'hCAFE_F00D, 2'b00, c1, l1);
    join
    chk("concurrent_aw_latency", l0, 1);
    chk("concurrent_ar_latency", l1, 1);
    chk("concurrent_same_grant_cycle", c0, c1);
    rd(1, 32'h0800_0008, 32'hA5A5_0000, 2'b00, c1, l1);

    // slow b on s0's write holds s1's write off until s0's b handshake plus one idle cycle
    b_hold = 20;
    fork
      wr(0, 32'h0800_000C, 32'h1111_2222, 4'hF, 0, 2'b00, c0, l0, w0);
      begin
        repeat (3) @(posedge clock); #1;
        wr(1, 32'h0800_0010, 32'h3333_4444, 4'hF, 0, 2'b00, c1, l1, w1);
      end
    join
    b_hold = 0;
    chk("bhold_s1_aw_after_s0_b", c1 - b_hs_cyc[0], 2);
    chk("bhold_s1_waited", 32'(l1 > 20), 32'h1);

    // error responses are forwarded untouched
    slv_bresp = 2'b10;
    wr(1, 32'h0800_0014, 32'h5555_6666, 4'hF, 1, 2'b10, c1, l1, w1);
    slv_bresp = 2'b00;
    slv_rresp = 2'b11;
    rd(0, 32'h0800_000C, 32'h1111_2222, 2'b11, c0, l0);
    slv_rresp = 2'b00;

    // reset while a read sits in R_DATA
    r_hold = 10;
    s_ar_valid[0] = 1'b1; s_ar_addr[0] = 32'h0800_0004;
    wait_hs(0, 2, c0, l0);
    s_ar_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_quiet("reset_in_rdata");
    @(posedge clock); #1;
    reset = 1'b1;
    r_hold = 0;
    rd(1, 32'h2000_0000, 32'hCAFE_F00D, 2'b00, c1, l1);
    chk("post_reset_s1_latency", l1, 1);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
